btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_btn_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: synchronizes and debounces two raw buttons, emits
// one-cycle press strobes, and adds hold-to-repeat on the move button.
// Ports:
//   clk, rst (sync, active-high)
//   button, button_rst : raw move / mode pushbuttons (1 = pressed)
//   repeat_en          : enables auto-repeat on the move channel
//   move_pulse, mode_pulse : one-cycle press (and move repeat) strobes
//   move_level, mode_level : debounced button levels

// Per-button front end: 2-flop synchronizer followed by a debounce counter.
// Ports: clk_i, rst_i, raw_i (async button), stable_o (debounced level).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

   logic        s1_q;
   logic        s2_q;
   logic        stable_q;
   logic        stable_d;
   logic [23:0] cnt_q;
   logic [23:0] cnt_d;

   // Any cycle where the synchronized input agrees with the accepted
   // level (a bounce back) restarts the count from zero.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + 24'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   input  logic button_rst,
   input  logic repeat_en,
   output logic move_pulse,
   output logic mode_pulse,
   output logic move_level,
   output logic mode_level
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [25:0] RD_MAX = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] RP_MAX = 26'(REPEAT_PERIOD - 1);

   logic        move_stable;
   logic        mode_stable;
   logic        move_level_q;
   logic        mode_level_q;
   logic        move_pulse_q;
   logic        mode_pulse_q;
   logic        move_rise;
   logic        mode_rise;
   logic        fire;
   logic [1:0]  st_q;
   logic [1:0]  st_d;
   logic [25:0] rcnt_q;
   logic [25:0] rcnt_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_move (
      .clk_i    (clk),
      .rst_i    (rst),
      .raw_i    (button),
      .stable_o (move_stable)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode (
      .clk_i    (clk),
      .rst_i    (rst),
      .raw_i    (button_rst),
      .stable_o (mode_stable)
   );

   // level_q is stable delayed one edge, so stable & ~level_q is true
   // exactly on the cycle after a 0->1 acceptance.
   assign move_rise = move_stable & ~move_level_q;
   assign mode_rise = mode_stable & ~mode_level_q;

   // Repeat FSM. A press can only happen from IDLE, so a repeat fire
   // never lands on the same edge as a press strobe.
   always_comb begin
      st_d   = st_q;
      rcnt_d = rcnt_q;
      fire   = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (move_rise) begin
               st_d   = ST_DELAY;
               rcnt_d = '0;
            end
         end
         ST_DELAY: begin
            if (!move_stable || !repeat_en) begin
               st_d   = ST_IDLE;
               rcnt_d = '0;
            end else if (rcnt_q == RD_MAX) begin
               fire   = 1'b1;
               st_d   = ST_REPEAT;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 26'd1;
            end
         end
         ST_REPEAT: begin
            if (!move_stable || !repeat_en) begin
               st_d   = ST_IDLE;
               rcnt_d = '0;
            end else if (rcnt_q == RP_MAX) begin
               fire   = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 26'd1;
            end
         end
         default: begin
            st_d   = ST_IDLE;
            rcnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         move_level_q <= 1'b0;
         mode_level_q <= 1'b0;
         move_pulse_q <= 1'b0;
         mode_pulse_q <= 1'b0;
         st_q         <= ST_IDLE;
         rcnt_q       <= '0;
      end else begin
         move_level_q <= move_stable;
         mode_level_q <= mode_stable;
         move_pulse_q <= move_rise | fire;
         mode_pulse_q <= mode_rise;
         st_q         <= st_d;
         rcnt_q       <= rcnt_d;
      end
   end

   assign move_pulse = move_pulse_q;
   assign mode_pulse = mode_pulse_q;
   assign move_level = move_level_q;
   assign mode_level = mode_level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
// Stimulus and expected outputs are per-edge bit masks written by hand.
module tb_btn_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic button;
   logic button_rst;
   logic repeat_en;
   logic move_pulse;
   logic mode_pulse;
   logic move_level;
   logic mode_level;

   int vectors     = 0;
   int miscompares = 0;

   // Bit e of each mask is the value at edge e (edge 1 = first after reset)
   logic [63:0] s_b;
   logic [63:0] s_m;
   logic [63:0] s_r;
   logic [63:0] s_x;
   logic [63:0] e_mp;
   logic [63:0] e_dp;
   logic [63:0] e_ml;
   logic [63:0] e_dl;

   always #5 clk = ~clk;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .button     (button),
      .button_rst (button_rst),
      .repeat_en  (repeat_en),
      .move_pulse (move_pulse),
      .mode_pulse (mode_pulse),
      .move_level (move_level),
      .mode_level (mode_level)
   );

   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m;
      m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string tag, input int e,
                      input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s edge %0d: observed %b expected %b",
                tag, e, obs, exp);
      end
   endtask

   task automatic clr();
      s_b  = '0;
      s_m  = '0;
      s_r  = '0;
      s_x  = '0;
      e_mp = '0;
      e_dp = '0;
      e_ml = '0;
      e_dl = '0;
   endtask

   task automatic run(input string name, input int last);
      rst        = 1'b1;
      button     = 1'b0;
      button_rst = 1'b0;
      repeat_en  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({name, ".rst_mp"}, 0, move_pulse, 1'b0);
      chk({name, ".rst_dp"}, 0, mode_pulse, 1'b0);
      chk({name, ".rst_ml"}, 0, move_level, 1'b0);
      chk({name, ".rst_dl"}, 0, mode_level, 1'b0);
      for (int e = 1; e <= last; e++) begin
         rst        = s_x[e];
         button     = s_b[e];
         button_rst = s_m[e];
         repeat_en  = s_r[e];
         @(posedge clk);
         #1;
         chk({name, ".move_pulse"}, e, move_pulse, e_mp[e]);
         chk({name, ".mode_pulse"}, e, mode_pulse, e_dp[e]);
         chk({name, ".move_level"}, e, move_level, e_ml[e]);
         chk({name, ".mode_level"}, e, mode_level, e_dl[e]);
      end
   endtask

   initial begin
      rst        = 1'b1;
      button     = 1'b0;
      button_rst = 1'b0;
      repeat_en  = 1'b0;

      // Press at edge 10, held: pulse and level at 16
      clr();
      s_b  = rng(10, 63);
      e_mp = rng(16, 16);
      e_ml = rng(16, 63);
      run("basic", 40);

      // Bounce 1,0,1,0 at 16..19, held from 20: pulse at 26
      clr();
      s_b  = rng(16, 16) | rng(18, 18) | rng(20, 63);
      e_mp = rng(26, 26);
      e_ml = rng(26, 63);
      run("bounce", 40);

      // Only DEBOUNCE_CYCLES-1 high samples: never accepted
      clr();
      s_b = rng(10, 12);
      run("short", 30);

      // Exactly DEBOUNCE_CYCLES high samples: accepted, then released
      clr();
      s_b  = rng(10, 13);
      e_mp = rng(16, 16);
      e_ml = rng(16, 19);
      run("exact", 30);

      // Auto-repeat, release sampled from 33 stops further pulses
      clr();
      s_b  = rng(10, 32);
      s_r  = rng(1, 63);
      e_mp = rng(16, 16) | rng(26, 26) | rng(31, 31) | rng(36, 36);
      e_ml = rng(16, 38);
      run("repeat", 50);

      // Same hold with repeat disabled: press pulse only
      clr();
      s_b  = rng(10, 32);
      e_mp = rng(16, 16);
      e_ml = rng(16, 38);
      run("norepeat", 50);

      // repeat_en dropped at 28 during REPEAT: no pulse at 31
      clr();
      s_b  = rng(10, 45);
      s_r  = rng(1, 27);
      e_mp = rng(16, 16) | rng(26, 26);
      e_ml = rng(16, 51);
      run("repdrop", 56);

      // Both buttons at 10; mode held, never repeats
      clr();
      s_b  = rng(10, 32);
      s_m  = rng(10, 63);
      e_mp = rng(16, 16);
      e_dp = rng(16, 16);
      e_ml = rng(16, 38);
      e_dl = rng(16, 63);
      run("dual", 50);

      // Reset at edge 14 mid-debounce: single pulse at 21
      clr();
      s_b  = rng(10, 63);
      s_x  = rng(14, 14);
      e_mp = rng(21, 21);
      e_ml = rng(21, 63);
      run("rstdeb", 40);

      // Reset at edge 29 mid-repeat: repeat aborted, re-press at 36
      clr();
      s_b  = rng(10, 63);
      s_r  = rng(1, 63);
      s_x  = rng(29, 29);
      e_mp = rng(16, 16) | rng(26, 26) | rng(36, 36)
           | rng(46, 46) | rng(51, 51) | rng(56, 56);
      e_ml = rng(16, 28) | rng(36, 63);
      run("rstrep", 58);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
